// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline control unit for a five-stage Y86-64 pipeline. It
//            detects load/use, ret, mispredict and exception hazards and
//            drives the stall/bubble controls of the F/D/E/M/W pipeline
//            registers. It also gates condition-code writes, keeps a sticky
//            halt state and maintains event counters.
// Ports    : clk, reset        - rising-edge clock, async active-high reset
//            D_icode           - icode in decode
//            d_srcA, d_srcB    - decode source registers (0xF = none)
//            E_icode, E_dstM   - execute icode / memory destination register
//            e_Cnd             - branch condition from execute
//            M_icode, m_status - memory-stage icode / status leaving memory
//            W_status          - status held in writeback register
//            F/D/W_stall       - hold pipeline register contents
//            D/E/M_bubble      - inject a nop into pipeline register
//            set_cc            - permit condition-code write
//            halted, halt_code - sticky halt flag and captured W_status
//            cyc/lu/mp/ret_cnt - event counters (wrap modulo 2^CNT_W)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_status,
  input  logic [3:0]       W_status,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [3:0]       halt_code,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [3:0] c_mrmovq = 4'h5;
  localparam logic [3:0] c_opq    = 4'h6;
  localparam logic [3:0] c_jxx    = 4'h7;
  localparam logic [3:0] c_ret    = 4'h9;
  localparam logic [3:0] c_popq   = 4'hB;
  localparam logic [3:0] c_aok    = 4'h1;
  localparam logic [3:0] c_rnone  = 4'hF;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       halt_code_q, halt_code_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  logic w_lu, w_mp, w_rt, w_mx, w_wx;

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  // A register ID of RNONE never produces a dependency, even if both the
  // load destination and a decode source read as 0xF.
  assign w_lu = ((E_icode == c_mrmovq) || (E_icode == c_popq)) &&
                (E_dstM != c_rnone) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mp = (E_icode == c_jxx) && !e_Cnd;
  assign w_rt = (D_icode == c_ret) || (E_icode == c_ret) || (M_icode == c_ret);
  assign w_mx = (m_status != c_aok);
  assign w_wx = (W_status != c_aok);

  // ---------------------------------------------------------------------------
  // Pipeline control outputs (combinational, zero latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    if (reset) begin
      // Flush the whole pipe while reset is held, independent of the clock.
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == ST_HALT) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      F_stall  = w_lu | w_rt;
      D_stall  = w_lu;
      // A load/use stall takes priority over the ret bubble in decode so the
      // ret is held rather than squashed.
      D_bubble = w_mp | (w_rt & ~w_lu);
      E_bubble = w_mp | w_lu;
      M_bubble = w_mx | w_wx;
      W_stall  = w_wx;
      set_cc   = (E_icode == c_opq) & ~w_mx & ~w_wx;
    end
  end

  // ---------------------------------------------------------------------------
  // Halt state machine and event counters: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    halt_code_d = halt_code_q;
    cyc_cnt_d   = cyc_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    mp_cnt_d    = mp_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    if (state_q == ST_RUN) begin
      // Counters still step on the edge that enters HALT.
      cyc_cnt_d = cyc_cnt_q + c_cnt_one;
      if (w_lu) begin
        lu_cnt_d = lu_cnt_q + c_cnt_one;
      end
      if (w_mp) begin
        mp_cnt_d = mp_cnt_q + c_cnt_one;
      end
      if (w_rt && !w_lu) begin
        ret_cnt_d = ret_cnt_q + c_cnt_one;
      end
      if (w_wx) begin
        state_d     = ST_HALT;
        halt_code_d = W_status;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      halt_code_q <= c_aok;
      cyc_cnt_q   <= '0;
      lu_cnt_q    <= '0;
      mp_cnt_q    <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_code_q <= halt_code_d;
      cyc_cnt_q   <= cyc_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      mp_cnt_q    <= mp_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign halted    = (state_q == ST_HALT);
  assign halt_code = halt_code_q;
  assign cyc_cnt   = cyc_cnt_q;
  assign lu_cnt    = lu_cnt_q;
  assign mp_cnt    = mp_cnt_q;
  assign ret_cnt   = ret_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Stimulus pushes the
//            expected response of a behavioural model into a scoreboard
//            queue; an independent monitor pops and compares on the falling
//            clock edge. A second instance with 4-bit counters exercises
//            counter wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [3:0] D_icode;
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       cnd;
    logic [3:0] M_icode;
    logic [3:0] m_status;
    logic [3:0] W_status;
  } stim_t;

  typedef struct {
    string           tag;
    logic            f_stall, d_stall, w_stall;
    logic            d_bub, e_bub, m_bub, setcc, halted;
    logic [3:0]      code;
    longint unsigned cyc, lu, mp, rt;
  } exp_t;

  typedef struct {
    bit lu, mp, rt, mx, wx;
  } hz_t;

  logic       clk;
  logic       reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_status, W_status;
  logic       e_Cnd;

  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
  logic [3:0]  halt_code;
  logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

  logic        w4_F_stall, w4_D_stall, w4_W_stall, w4_D_bubble, w4_E_bubble, w4_M_bubble;
  logic        w4_set_cc, w4_halted;
  logic [3:0]  w4_halt_code;
  logic [3:0]  w4_cyc_cnt, w4_lu_cnt, w4_mp_cnt, w4_ret_cnt;

  pipe_hazard_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_status(m_status), .W_status(W_status),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .halted(halted), .halt_code(halt_code),
    .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_status(m_status), .W_status(W_status),
    .F_stall(w4_F_stall), .D_stall(w4_D_stall), .W_stall(w4_W_stall),
    .D_bubble(w4_D_bubble), .E_bubble(w4_E_bubble), .M_bubble(w4_M_bubble),
    .set_cc(w4_set_cc), .halted(w4_halted), .halt_code(w4_halt_code),
    .cyc_cnt(w4_cyc_cnt), .lu_cnt(w4_lu_cnt), .mp_cnt(w4_mp_cnt), .ret_cnt(w4_ret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state: the register contents after the most recent edge
  // whose inputs have already been accounted for.
  // ---------------------------------------------------------------------------
  bit              mdl_halted;
  logic [3:0]      mdl_code;
  longint unsigned mdl_cyc, mdl_lu, mdl_mp, mdl_rt;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic hz_t hazards(input stim_t s);
    hz_t h;
    bit  is_load;
    is_load = (s.E_icode == 4'h5) || (s.E_icode == 4'hB);
    h.lu = is_load && (s.E_dstM != 4'hF) && ((s.E_dstM == s.srcA) || (s.E_dstM == s.srcB));
    h.mp = (s.E_icode == 4'h7) && !s.cnd;
    h.rt = (s.D_icode == 4'h9) || (s.E_icode == 4'h9) || (s.M_icode == 4'h9);
    h.mx = (s.m_status != 4'h1);
    h.wx = (s.W_status != 4'h1);
    return h;
  endfunction

  function automatic exp_t predict(input stim_t s, input string tag);
    exp_t e;
    hz_t  h;
    h = hazards(s);
    e.tag = tag;
    if (s.rst) begin
      {e.f_stall, e.d_stall, e.w_stall} = 3'b000;
      {e.d_bub, e.e_bub, e.m_bub}       = 3'b111;
      e.setcc  = 1'b0;
      e.halted = 1'b0;
      e.code   = 4'h1;
      e.cyc = 0; e.lu = 0; e.mp = 0; e.rt = 0;
    end else begin
      if (mdl_halted) begin
        {e.f_stall, e.d_stall, e.w_stall} = 3'b111;
        {e.d_bub, e.e_bub, e.m_bub}       = 3'b011;
        e.setcc = 1'b0;
      end else begin
        e.f_stall = h.lu || h.rt;
        e.d_stall = h.lu;
        e.w_stall = h.wx;
        e.d_bub   = h.mp || (h.rt && !h.lu);
        e.e_bub   = h.mp || h.lu;
        e.m_bub   = h.mx || h.wx;
        e.setcc   = (s.E_icode == 4'h6) && !h.mx && !h.wx;
      end
      e.halted = mdl_halted;
      e.code   = mdl_code;
      e.cyc = mdl_cyc; e.lu = mdl_lu; e.mp = mdl_mp; e.rt = mdl_rt;
    end
    return e;
  endfunction

  // Account for one rising edge taken with inputs s.
  task automatic advance(input stim_t s);
    hz_t h;
    h = hazards(s);
    if (!mdl_halted) begin
      mdl_cyc++;
      if (h.lu) mdl_lu++;
      if (h.mp) mdl_mp++;
      if (h.rt && !h.lu) mdl_rt++;
      if (h.wx) begin
        mdl_halted = 1'b1;
        mdl_code   = s.W_status;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    reset    = s.rst;
    D_icode  = s.D_icode;
    d_srcA   = s.srcA;
    d_srcB   = s.srcB;
    E_icode  = s.E_icode;
    E_dstM   = s.E_dstM;
    e_Cnd    = s.cnd;
    M_icode  = s.M_icode;
    m_status = s.m_status;
    W_status = s.W_status;
  endtask

  function automatic stim_t nop_stim();
    stim_t s;
    s.rst = 1'b0; s.D_icode = 4'h1; s.srcA = 4'hF; s.srcB = 4'hF;
    s.E_icode = 4'h1; s.E_dstM = 4'hF; s.cnd = 1'b0; s.M_icode = 4'h1;
    s.m_status = 4'h1; s.W_status = 4'h1;
    return s;
  endfunction

  task automatic step(input stim_t s, input string tag);
    @(posedge clk);
    #1;
    drive(s);
    sb.push_back(predict(s, tag));
    advance(s);
  endtask

  // Reset asserted and released strictly between rising edges.
  task automatic pulse_reset(input stim_t s, input string tag);
    @(posedge clk);
    #1;
    s.rst = 1'b1;
    drive(s);
    sb.push_back(predict(s, tag));
    mdl_halted = 1'b0; mdl_code = 4'h1;
    mdl_cyc = 0; mdl_lu = 0; mdl_mp = 0; mdl_rt = 0;
    @(negedge clk);
    #1;
    s.rst = 1'b0;
    reset = 1'b0;
    advance(s);
  endtask

  function automatic logic [3:0] rand_icode();
    case ($urandom_range(0, 9))
      0: return 4'h1;
      1: return 4'h3;
      2: return 4'h5;
      3: return 4'h6;
      4: return 4'h7;
      5: return 4'h8;
      6: return 4'h9;
      7: return 4'hA;
      8: return 4'hB;
      default: return 4'h5;
    endcase
  endfunction

  function automatic logic [3:0] rand_reg();
    int unsigned r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  function automatic stim_t rand_stim(input bit allow_wx);
    stim_t s;
    s.rst      = 1'b0;
    s.D_icode  = rand_icode();
    s.srcA     = rand_reg();
    s.srcB     = rand_reg();
    s.E_icode  = rand_icode();
    s.E_dstM   = rand_reg();
    s.cnd      = 1'($urandom_range(0, 1));
    s.M_icode  = rand_icode();
    s.m_status = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
    s.W_status = (allow_wx && $urandom_range(0, 29) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
  endtask

  initial begin : g_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.tag, "F_stall",   64'(F_stall),   64'(e.f_stall));
        chk(e.tag, "D_stall",   64'(D_stall),   64'(e.d_stall));
        chk(e.tag, "W_stall",   64'(W_stall),   64'(e.w_stall));
        chk(e.tag, "D_bubble",  64'(D_bubble),  64'(e.d_bub));
        chk(e.tag, "E_bubble",  64'(E_bubble),  64'(e.e_bub));
        chk(e.tag, "M_bubble",  64'(M_bubble),  64'(e.m_bub));
        chk(e.tag, "set_cc",    64'(set_cc),    64'(e.setcc));
        chk(e.tag, "halted",    64'(halted),    64'(e.halted));
        chk(e.tag, "halt_code", 64'(halt_code), 64'(e.code));
        chk(e.tag, "cyc_cnt",   64'(cyc_cnt),   e.cyc & 64'hFFFF_FFFF);
        chk(e.tag, "lu_cnt",    64'(lu_cnt),    e.lu  & 64'hFFFF_FFFF);
        chk(e.tag, "mp_cnt",    64'(mp_cnt),    e.mp  & 64'hFFFF_FFFF);
        chk(e.tag, "ret_cnt",   64'(ret_cnt),   e.rt  & 64'hFFFF_FFFF);
        chk(e.tag, "cyc_cnt4",  64'(w4_cyc_cnt), e.cyc % 16);
        chk(e.tag, "lu_cnt4",   64'(w4_lu_cnt),  e.lu  % 16);
        chk(e.tag, "ret_cnt4",  64'(w4_ret_cnt), e.rt  % 16);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : g_stimulus
    stim_t s;
    mdl_halted = 1'b0; mdl_code = 4'h1;
    mdl_cyc = 0; mdl_lu = 0; mdl_mp = 0; mdl_rt = 0;
    s = nop_stim();
    s.rst = 1'b1;
    drive(s);

    pulse_reset(nop_stim(), "reset_state");
    step(nop_stim(), "first_count");

    // Load/use on srcA, then the RNONE case that must not stall.
    s = nop_stim(); s.E_icode = 4'h5; s.E_dstM = 4'h3; s.srcA = 4'h3;
    step(s, "lu_srcA");
    s = nop_stim(); s.E_icode = 4'h5; s.E_dstM = 4'hF;
    step(s, "lu_rnone");
    s = nop_stim(); s.E_icode = 4'hB; s.E_dstM = 4'h2; s.srcB = 4'h2;
    step(s, "lu_pop_srcB");

    // Mispredict vs taken branch.
    s = nop_stim(); s.E_icode = 4'h7; s.cnd = 1'b0;
    step(s, "mispredict");
    s.cnd = 1'b1;
    step(s, "taken_jxx");

    // ret moving D -> E -> M.
    s = nop_stim(); s.D_icode = 4'h9; step(s, "ret_D");
    s = nop_stim(); s.E_icode = 4'h9; step(s, "ret_E");
    s = nop_stim(); s.M_icode = 4'h9; step(s, "ret_M");
    step(nop_stim(), "ret_done");
    s = nop_stim(); s.D_icode = 4'h9; s.E_icode = 4'h5; s.E_dstM = 4'h2; s.srcB = 4'h2;
    step(s, "ret_lu");
    step(nop_stim(), "ret_lu_after");

    // Condition-code gating.
    s = nop_stim(); s.E_icode = 4'h6; step(s, "setcc_ok");
    s.m_status = 4'h4; step(s, "setcc_mx");

    // Exception halt and sticky behaviour.
    s = nop_stim(); s.E_icode = 4'h6; s.W_status = 4'h3; step(s, "exc_W");
    s = nop_stim(); s.E_icode = 4'h5; s.E_dstM = 4'h1; s.srcA = 4'h1;
    step(s, "halt_hold0");
    s = nop_stim(); s.W_status = 4'h4; step(s, "halt_hold1");
    s = nop_stim(); s.D_icode = 4'h9; step(s, "halt_hold2");
    pulse_reset(nop_stim(), "reset_in_halt");

    // Long run without writeback exceptions so the 4-bit counters wrap.
    for (int i = 0; i < 40; i++) step(rand_stim(1'b0), "rand_nowx");

    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 60; i++) step(rand_stim(1'b1), "rand");
      pulse_reset(rand_stim(1'b1), "rand_reset");
    end
    step(nop_stim(), "final");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. It drives the stall and bubble inputs of the fetch, decode, execute, memory and writeback pipeline registers. It resolves load/use hazards, `ret` processing, mispredicted branches and exceptions, and gates condition-code updates. It also holds a sticky halt state and a set of event counters that a bench or debug port can read.

## Interface
Parameters:
- `CNT_W`, 32, width of each event counter

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `D_icode`  in  4  icode in decode stage
- `d_srcA`, `d_srcB`  in  4  decode source register IDs; 0xF means none
- `E_icode`  in  4  icode in execute stage
- `E_dstM`  in  4  execute-stage memory destination register
- `e_Cnd`  in  1  branch condition computed in execute
- `M_icode`  in  4  icode in memory stage
- `m_status`  in  4  status leaving memory stage
- `W_status`  in  4  status held in writeback register
- `F_stall`, `D_stall`, `W_stall`  out  1  hold the register's contents
- `D_bubble`, `E_bubble`, `M_bubble`  out  1  load a nop (icode 1, status AOK) into the register
- `set_cc`  out  1  permit a condition-code write this cycle
- `halted`  out  1  sticky halt flag
- `halt_code`  out  4  W_status value captured at halt
- `cyc_cnt`, `lu_cnt`, `mp_cnt`, `ret_cnt`  out  `CNT_W`  event counters: cycles, load/use stalls, mispredicts, ret bubbles

## Operation
Encodings:
- icode: HALT 0, NOP 1, IRMOVQ 3, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B
- status: AOK 1, HLT 2, ADR 3, INS 4; any value other than 1 counts as exceptional
- RNONE is 0xF

Hazard terms, all combinational:
- `lu` = `E_icode` ∈ {MRMOVQ, POPQ} and `E_dstM` ≠ RNONE and `E_dstM` ∈ {`d_srcA`, `d_srcB`}
- `mp` = `E_icode`=JXX and `e_Cnd`=0
- `rt` = RET ∈ {`D_icode`, `E_icode`, `M_icode`}
- `mx` = `m_status` exceptional; `wx` = `W_status` exceptional

Outputs when running (`halted`=0, `reset`=0):
- `F_stall` = `lu` | `rt`
- `D_stall` = `lu`
- `D_bubble` = `mp` | (`rt` & !`lu`)
- `E_bubble` = `mp` | `lu`
- `M_bubble` = `mx` | `wx`
- `W_stall` = `wx`
- `set_cc` = (`E_icode`=OPQ) & !`mx` & !`wx`

Invariants:
- `D_stall` and `D_bubble` are never both 1.
- `lu` and `mp` cannot both be 1, because `E_icode` cannot be a load and JXX at once.

Halt state machine, two states:
- RUN → HALT at the posedge where `wx`=1; `halt_code` captures `W_status` on the same edge.
- HALT holds until `reset`. Later changes to `W_status` do not update `halt_code`.

Outputs in HALT:
- `F_stall`=`D_stall`=`W_stall`=1
- `E_bubble`=`M_bubble`=1
- `D_bubble`=0, `set_cc`=0

Counters, all in RUN only; each wraps modulo 2^`CNT_W` with no saturation:
- `cyc_cnt` +1 every cycle
- `lu_cnt` +1 when `lu`
- `mp_cnt` +1 when `mp`
- `ret_cnt` +1 when `rt` & !`lu`

All counters freeze in HALT.

## Timing
- Hazard outputs are combinational from the current inputs and `halted`, with zero latency. They are sampled by the pipeline registers at the next posedge.
- Values while `reset`=1, asynchronous and independent of `clk`:
  - `halted`=0, `halt_code`=1 (AOK), all counters 0
  - `F_stall`=`D_stall`=`W_stall`=0
  - `D_bubble`=`E_bubble`=`M_bubble`=1, `set_cc`=0, which flushes the pipe
- Reset asserted mid-operation, including in HALT, returns the block to these values immediately.
- First counting edge after reset deassertion: `cyc_cnt` reads 1 after it.
- `halted` rises one posedge after `wx` is first seen. During that cycle the combinational `W_stall`/`M_bubble` already hold the pipe.
- Counter increment and halt entry occur on the same edge: counters still increment on the entry edge and stop from the next edge.
- A `ret` stays pending for 3 cycles as it moves D→E→M. `ret_cnt` +3 per isolated `ret`.

## Test plan
- **Load/use:** `E_icode`=5, `E_dstM`=3, `d_srcA`=3, `reset`=0 → `F_stall`=`D_stall`=`E_bubble`=1, `D_bubble`=0; `lu_cnt` 0→1 after one edge. Same with `d_srcB`=`d_srcA`=0xF and `E_dstM`=0xF → no stall.
- **Mispredict:** `E_icode`=7, `e_Cnd`=0 → `D_bubble`=`E_bubble`=1, `F_stall`=0. With `e_Cnd`=1 → all controls 0.
- **Ret sequence:** `D_icode`=9, then `E_icode`=9, then `M_icode`=9 over 3 cycles → `F_stall`=`D_bubble`=1 each cycle; `ret_cnt`=3. Ret in D plus `lu` → `D_stall`=1, `D_bubble`=0, `ret_cnt` unchanged.
- **Exception halt:** `W_status`=3 → `W_stall`=`M_bubble`=1 immediately, `set_cc`=0 with `E_icode`=6. After the edge: `halted`=1, `halt_code`=3. Then `W_status`=1 → `halted` stays 1, counters frozen.
- **`set_cc` gating:** `E_icode`=6, `m_status`=1, `W_status`=1 → `set_cc`=1. `m_status`=4 → `set_cc`=0, `M_bubble`=1.
- **Async reset in HALT:** pulse `reset` between clock edges → `halted`=0, `halt_code`=1, counters 0, and all three bubbles 1 without waiting for a clock edge. Also: force `cyc_cnt` to all-ones with `CNT_W`=4 → wraps to 0.
